// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared constants and types for the four-digit multiplexed display scanner.
//   DIGITS          number of digit positions being scanned
//   CNT_W           width of the per-digit prescaler counter
//   CLK_DIV_DEFAULT default clk cycles per digit slot
//   digit_idx_t     2-bit digit index
//   hex_t           one hex nibble
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam int          DIGITS          = 4;
    localparam int          CNT_W           = 16;
    localparam int unsigned CLK_DIV_DEFAULT = 50000;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] hex_t;

    localparam digit_idx_t LAST_IDX = 2'd3;

endpackage

// File: rtl/seg_tick_gen.sv
// ---------------------------------------------------------------------------
// seg_tick_gen
// Free-running prescaler that counts 0..CLK_DIV-1 and wraps. tick is high
// for the single cycle in which the counter holds CLK_DIV-1, so the scanner
// advances once every CLK_DIV clocks.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset (counter returns to 0)
//   tick   combinational, high when the counter is at its last value
// ---------------------------------------------------------------------------
module seg_tick_gen
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Scans four hex digits onto a shared BCD/hex-to-7-segment decoder with
// active-low anode selects. New content is captured into a shadow (pending)
// set by load and only copied into the displayed (active) set at the end of
// a full four-digit frame, so a frame never shows a mix of old and new data.
// Ports:
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   data_in     four hex digits, digit k = data_in[4k+3:4k]
//   points_in   decimal point request per digit, active-high
//   blank_in    per-digit blank mask, 1 = digit dark
//   load        single-cycle capture strobe for the three inputs above
//   hex_out     registered digit code for the decoder
//   le          registered decoder blank, 1 = all segments off
//   point       registered decimal point for the current digit
//   an          registered anode selects, active-low one-hot
//   pend        a captured load is waiting for the end of the frame
//   frame_done  one-cycle pulse in the cycle after each frame wrap
// Build option:
//   SEG_LZB_EN  when defined, digits above the most significant non-zero
//               active digit are blanked (digit 0 is never auto-blanked).
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]   points_in,
    input  logic [DIGITS-1:0]   blank_in,
    input  logic                load,
    output logic [3:0]          hex_out,
    output logic                le,
    output logic                point,
    output logic [DIGITS-1:0]   an,
    output logic                pend,
    output logic                frame_done
);

    logic tick;
    logic wrap;

    seg_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Scan position and frame boundary
    digit_idx_t idx_q;
    digit_idx_t idx_d;

    assign wrap  = tick && (idx_q == LAST_IDX);
    assign idx_d = tick ? idx_q + 2'd1 : idx_q;

    // Displayed (active) and shadow (pending) register sets
    logic [4*DIGITS-1:0] act_data_q,  act_data_d;
    logic [DIGITS-1:0]   act_pts_q,   act_pts_d;
    logic [DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [4*DIGITS-1:0] pnd_data_q,  pnd_data_d;
    logic [DIGITS-1:0]   pnd_pts_q,   pnd_pts_d;
    logic [DIGITS-1:0]   pnd_blank_q, pnd_blank_d;
    logic                pend_q,      pend_d;

    always_comb begin
        act_data_d  = act_data_q;
        act_pts_d   = act_pts_q;
        act_blank_d = act_blank_q;
        pnd_data_d  = pnd_data_q;
        pnd_pts_d   = pnd_pts_q;
        pnd_blank_d = pnd_blank_q;
        pend_d      = pend_q;

        if (load && wrap) begin
            // Arriving exactly at the frame boundary: nothing to defer,
            // and it supersedes any older pending capture.
            act_data_d  = data_in;
            act_pts_d   = points_in;
            act_blank_d = blank_in;
            pend_d      = 1'b0;
        end else begin
            if (wrap && pend_q) begin
                act_data_d  = pnd_data_q;
                act_pts_d   = pnd_pts_q;
                act_blank_d = pnd_blank_q;
                pend_d      = 1'b0;
            end
            // Later loads in the same frame simply overwrite the shadow.
            if (load) begin
                pnd_data_d  = data_in;
                pnd_pts_d   = points_in;
                pnd_blank_d = blank_in;
                pend_d      = 1'b1;
            end
        end
    end

    // Per-digit view of the active data
    hex_t act_digit [DIGITS];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign act_digit[gi] = act_data_q[4*gi +: 4];
        end
    endgenerate

`ifdef SEG_LZB_EN
    // lzb_mask[k] is set when every active digit at position k and above
    // is zero; position 0 always stays lit.
    logic [DIGITS-1:0] lzb_mask;

    assign lzb_mask[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lzb
            assign lzb_mask[gi] = (act_data_q[4*DIGITS-1:4*gi] == '0);
        end
    endgenerate
`endif

    // Registered decoder/anode outputs, one cycle behind idx_q
    logic [3:0]        hex_q,   hex_d;
    logic              le_q,    le_d;
    logic              point_q, point_d;
    logic [DIGITS-1:0] an_q,    an_d;
    logic              fd_q,    fd_d;

    always_comb begin
        hex_d   = act_digit[idx_q];
        point_d = act_pts_q[idx_q];
        an_d    = ~(4'b0001 << idx_q);
`ifdef SEG_LZB_EN
        le_d    = act_blank_q[idx_q] | lzb_mask[idx_q];
`else
        le_d    = act_blank_q[idx_q];
`endif
        fd_d    = wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            act_data_q  <= '0;
            act_pts_q   <= '0;
            act_blank_q <= '0;
            pnd_data_q  <= '0;
            pnd_pts_q   <= '0;
            pnd_blank_q <= '0;
            pend_q      <= 1'b0;
            hex_q       <= '0;
            le_q        <= 1'b1;
            point_q     <= 1'b0;
            an_q        <= '1;
            fd_q        <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            act_data_q  <= act_data_d;
            act_pts_q   <= act_pts_d;
            act_blank_q <= act_blank_d;
            pnd_data_q  <= pnd_data_d;
            pnd_pts_q   <= pnd_pts_d;
            pnd_blank_q <= pnd_blank_d;
            pend_q      <= pend_d;
            hex_q       <= hex_d;
            le_q        <= le_d;
            point_q     <= point_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    assign hex_out    = hex_q;
    assign le         = le_q;
    assign point      = point_q;
    assign an         = an_q;
    assign pend       = pend_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with CLK_DIV=4 (16 clocks per frame).
// Outputs are sampled on the falling edge. A frame check starts at a falling
// edge where frame_done is high and inspects the next 16 falling edges.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic [3:0]  points_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [3:0]  hex_out;
    logic        le;
    logic        point;
    logic [3:0]  an;
    logic        pend;
    logic        frame_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .CLK_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .points_in  (points_in),
        .blank_in   (blank_in),
        .load       (load),
        .hex_out    (hex_out),
        .le         (le),
        .point      (point),
        .an         (an),
        .pend       (pend),
        .frame_done (frame_done)
    );

    typedef struct {
        string       name;
        logic [15:0] data;
        logic [3:0]  pts;
        logic [3:0]  blank;
        logic [15:0] exp_hex;
        logic [3:0]  exp_pt;
        logic [3:0]  exp_le;
    } vec_t;

    logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data_in   = d;
        points_in = p;
        blank_in  = b;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    // Advance to the next falling edge that shows frame_done, bounded.
    task automatic wait_frame(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = frame_done;
        end
        chk({name, " frame_done within bound"}, 32'(seen), 32'd1);
    endtask

    // Verify one full frame of display content. When ld is set, nxt is
    // loaded on the first cycle and must stay pending (not shown) until the
    // frame boundary at the end.
    task automatic check_frame(input vec_t cur, input bit ld, input vec_t nxt);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                bit last = (s == 3) && (c == 3);
                if (ld && s == 0 && c == 0) begin
                    data_in   = nxt.data;
                    points_in = nxt.pts;
                    blank_in  = nxt.blank;
                    load      = 1'b1;
                end
                @(negedge clk);
                load = 1'b0;
                chk($sformatf("%s an d%0d c%0d", cur.name, s, c), 32'(an), 32'(an_exp[s]));
                chk($sformatf("%s hex d%0d c%0d", cur.name, s, c), 32'(hex_out), 32'(cur.exp_hex[4*s +: 4]));
                chk($sformatf("%s point d%0d c%0d", cur.name, s, c), 32'(point), 32'(cur.exp_pt[s]));
                chk($sformatf("%s le d%0d c%0d", cur.name, s, c), 32'(le), 32'(cur.exp_le[s]));
                chk($sformatf("%s frame_done d%0d c%0d", cur.name, s, c), 32'(frame_done), 32'(last));
                chk($sformatf("%s pend d%0d c%0d", cur.name, s, c), 32'(pend), 32'(ld && !last));
            end
        end
        $display("frame %s checked%s", cur.name, ld ? {" with load of ", nxt.name} : "");
    endtask

    task automatic check_reset_state(input string name);
        chk({name, " an"}, 32'(an), 32'hF);
        chk({name, " hex"}, 32'(hex_out), 32'h0);
        chk({name, " le"}, 32'(le), 32'h1);
        chk({name, " point"}, 32'(point), 32'h0);
        chk({name, " pend"}, 32'(pend), 32'h0);
        chk({name, " frame_done"}, 32'(frame_done), 32'h0);
    endtask

    vec_t zero_v;
    vec_t vecs [4];
    vec_t prev;
    vec_t v11, v22, vc0, vaa;

    initial begin
        rst_n     = 1'b0;
        data_in   = '0;
        points_in = '0;
        blank_in  = '0;
        load      = 1'b0;

`ifdef SEG_LZB_EN
        zero_v = '{"zeros", 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b1110};
        vc0    = '{"00C0",  16'h00C0, 4'b0000, 4'b0000, 16'h00C0, 4'b0000, 4'b1100};
        vecs[2] = '{"0000_b0110", 16'h0000, 4'b1111, 4'b0110, 16'h0000, 4'b1111, 4'b1110};
`else
        zero_v = '{"zeros", 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000};
        vc0    = '{"00C0",  16'h00C0, 4'b0000, 4'b0000, 16'h00C0, 4'b0000, 4'b0000};
        vecs[2] = '{"0000_b0110", 16'h0000, 4'b1111, 4'b0110, 16'h0000, 4'b1111, 4'b0110};
`endif
        vecs[0] = '{"12AF_p0100", 16'h12AF, 4'b0100, 4'b0000, 16'h12AF, 4'b0100, 4'b0000};
        vecs[1] = '{"5678_b1001", 16'h5678, 4'b0000, 4'b1001, 16'h5678, 4'b0000, 4'b1001};
        vecs[3] = '{"BEEF_p1000", 16'hBEEF, 4'b1000, 4'b0000, 16'hBEEF, 4'b1000, 4'b0000};
        v11 = '{"1111", 16'h1111, 4'b0000, 4'b0000, 16'h1111, 4'b0000, 4'b0000};
        v22 = '{"2222", 16'h2222, 4'b0011, 4'b0000, 16'h2222, 4'b0011, 4'b0000};
        vaa = '{"AAAA", 16'hAAAA, 4'b1111, 4'b1111, 16'hAAAA, 4'b1111, 4'b1111};

        // Reset held for a few cycles
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        $display("reset state checked");

        // Release: scan starts at digit 0 showing zeros
        rst_n = 1'b1;
        check_frame(zero_v, 1'b0, zero_v);

        // Table: each vector loaded mid-frame, shown from the next frame
        prev = zero_v;
        for (int i = 0; i < 4; i++) begin
            check_frame(prev, 1'b1, vecs[i]);
            prev = vecs[i];
        end
        check_frame(prev, 1'b0, prev);

        // Two loads in one frame: last one wins
        do_load(v11.data, v11.pts, v11.blank);
        chk("double load pend after first", 32'(pend), 32'd1);
        repeat (3) @(negedge clk);
        do_load(v22.data, v22.pts, v22.blank);
        chk("double load pend after second", 32'(pend), 32'd1);
        wait_frame("double load");
        chk("double load pend at wrap", 32'(pend), 32'd0);
        check_frame(v22, 1'b0, v22);

        // Load exactly on the wrap edge: direct to active, pend never set
        repeat (15) @(negedge clk);
        chk("wrap load pend before", 32'(pend), 32'd0);
        do_load(vc0.data, vc0.pts, vc0.blank);
        chk("wrap load frame_done", 32'(frame_done), 32'd1);
        chk("wrap load pend", 32'(pend), 32'd0);
        $display("load on wrap edge applied");
        check_frame(vc0, 1'b0, vc0);

        // Reset mid-frame with a pending load: pending is discarded
        do_load(vaa.data, vaa.pts, vaa.blank);
        chk("mid reset pend before", 32'(pend), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("mid reset");
        $display("mid-frame reset checked");
        check_frame(zero_v, 1'b0, zero_v);
        check_frame(zero_v, 1'b0, zero_v);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
